// File: rtl/fp_comp_arbiter_if.sv
// Request/response and comparator-side signals of the shared fp_comp arbiter.
// The master side is the issue logic plus the comparator; the slave side is the arbiter.
interface fp_comp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_eq;
  logic                 rsp_great;
  logic                 rsp_less;
  logic                 rsp_inv;
  logic [31:0]          cmp_in1;
  logic [31:0]          cmp_in2;
  logic                 cmp_act;
  logic                 cmp_eq;
  logic                 cmp_great;
  logic                 cmp_less;
  logic                 cmp_inv;
  logic                 cmp_done;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
           cmp_eq, cmp_great, cmp_less, cmp_inv, cmp_done,
    input  req_ready, rsp_valid, rsp_id, rsp_eq, rsp_great, rsp_less, rsp_inv,
           cmp_in1, cmp_in2, cmp_act
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
           cmp_eq, cmp_great, cmp_less, cmp_inv, cmp_done,
    output req_ready, rsp_valid, rsp_id, rsp_eq, rsp_great, rsp_less, rsp_inv,
           cmp_in1, cmp_in2, cmp_act
  );
endinterface

// File: rtl/fp_comp_arbiter.sv
// Round-robin arbiter/sequencer sharing one fp_comp comparator among NREQ requesters.
//   state | meaning
//   IDLE  | waiting for a request; grant the next valid requester after ptr
//   ISSUE | operands held, cmp_act high, waiting CMP_LAT cycles plus cmp_done
//   RESP  | flags and id held on the response channel until accepted
module fp_comp_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int CMP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  fp_comp_arbiter_if.slave  bus,
  output logic              busy
);

  localparam int CW = $clog2(CMP_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic           gnt_found;
  logic [CW-1:0]  cnt;
  logic           cnt_done;

  assign cnt_done = (cnt == CW'(CMP_LAT));

  // Search upward from ptr+1 with wrap; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.cmp_act   = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (gnt_found) begin
          bus.req_ready[gnt_id] = rst;
          state_nxt             = ISSUE;
        end
      end
      ISSUE: begin
        bus.cmp_act = 1'b1;
        if (cnt_done && bus.cmp_done) state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr           <= IDW'(NREQ - 1);
      cnt           <= '0;
      bus.cmp_in1   <= '0;
      bus.cmp_in2   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_eq    <= 1'b0;
      bus.rsp_great <= 1'b0;
      bus.rsp_less  <= 1'b0;
      bus.rsp_inv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            bus.cmp_in1 <= bus.req_a[{gnt_id, 5'd0} +: 32];
            bus.cmp_in2 <= bus.req_b[{gnt_id, 5'd0} +: 32];
            bus.rsp_id  <= gnt_id;
            ptr         <= gnt_id;
            cnt         <= '0;
          end
        end
        ISSUE: begin
          if (!cnt_done) cnt <= cnt + CW'(1);
          if (cnt_done && bus.cmp_done) begin
            bus.rsp_eq    <= bus.cmp_eq;
            bus.rsp_great <= bus.cmp_great;
            bus.rsp_less  <= bus.cmp_less;
            bus.rsp_inv   <= bus.cmp_inv;
            bus.rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_comp_arbiter.sv
// Directed bench for fp_comp_arbiter: grant order, latency, back-pressure, late done, reset.
module tb_fp_comp_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_comp_arbiter_if #(.NREQ(4), .IDW(2)) bus();

  fp_comp_arbiter #(.NREQ(4), .IDW(2), .CMP_LAT(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  task automatic drive_cmp(input logic eq, input logic gt, input logic lt,
                           input logic inv, input logic done);
    bus.cmp_eq = eq; bus.cmp_great = gt; bus.cmp_less = lt;
    bus.cmp_inv = inv; bus.cmp_done = done;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.req_ready == 4'b0 && n < 20) begin @(negedge clk); #1; n++; end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.cmp_act !== 1'b0) begin errors++; $display("FAIL rst_cmp_act: got %b want 0", bus.cmp_act); end
    checks++; if ({bus.cmp_in1, bus.cmp_in2} !== 64'h0) begin errors++; $display("FAIL rst_operands: got %h want 0", {bus.cmp_in1, bus.cmp_in2}); end
    checks++; if ({bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv} !== 6'b0) begin
      errors++; $display("FAIL rst_rsp_fields: got %b want 000000", {bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv}); end
    bus.req_valid = 4'b0000;
    rst = 1'b1;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    bus.req_a[31:0] = 32'h3F800000; bus.req_b[31:0] = 32'h40000000;
    drive_cmp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0000; #1;
    checks++; if (bus.cmp_act !== 1'b1) begin errors++; $display("FAIL single_act_t1: got %b want 1", bus.cmp_act); end
    checks++; if ({bus.cmp_in1, bus.cmp_in2} !== 64'h3F800000_40000000) begin
      errors++; $display("FAIL single_operands: got %h want 3f80000040000000", {bus.cmp_in1, bus.cmp_in2}); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL single_ready_busy: got %b want 0000", bus.req_ready); end
    @(negedge clk); #1;
    checks++; if (bus.cmp_act !== 1'b1) begin errors++; $display("FAIL single_act_t2: got %b want 1", bus.cmp_act); end
    @(negedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp_t3: got %b want 0", bus.rsp_valid); end
    @(negedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_t4: got %b want 1", bus.rsp_valid); end
    checks++; if ({bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv} !== 6'b00_0010) begin
      errors++; $display("FAIL single_rsp_fields: got %b want 000010", {bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv}); end
    checks++; if (bus.cmp_act !== 1'b0) begin errors++; $display("FAIL single_act_resp: got %b want 0", bus.cmp_act); end
    @(negedge clk); #1;
    checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_idle_after: got %b want 00", {bus.rsp_valid, busy}); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    int n;
    int t_prev;
    t_prev = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    drive_cmp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      wait_ready(n);
      checks++; if (n >= 20) begin errors++; $display("FAIL cont_grant_timeout[%0d]: waited %0d want <20", k, n); end
      checks++; if (bus.req_ready !== exp_g) begin errors++; $display("FAIL cont_grant[%0d]: got %b want %b", k, bus.req_ready, exp_g); end
      if (k > 0) begin
        checks++; if (cyc - t_prev != 5) begin errors++; $display("FAIL cont_spacing[%0d]: got %0d want 5", k, cyc - t_prev); end
      end
      t_prev = cyc;
      @(negedge clk); bus.req_valid = bus.req_valid & ~exp_g; #1;
      wait_rsp(n);
      checks++; if (bus.rsp_id !== 2'(k) || bus.rsp_eq !== 1'b1) begin
        errors++; $display("FAIL cont_rsp[%0d]: got id %0d eq %b want id %0d eq 1", k, bus.rsp_id, bus.rsp_eq, k); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_rotation();
    int n;
    @(negedge clk); bus.req_valid = 4'b0100; #1;
    wait_ready(n);
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL rot_grant2: got %b want 0100", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b1010; #1;
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rot_ready_in_issue: got %b want 0000", bus.req_ready); end
    wait_rsp(n);
    @(negedge clk); #1;
    wait_ready(n);
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rot_grant3_first: got %b want 1000", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0010; #1;
    wait_rsp(n);
    @(negedge clk); #1;
    wait_ready(n);
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rot_grant1_second: got %b want 0010", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0000; #1;
    wait_rsp(n);
    checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL rot_rsp_id: got %0d want 1", bus.rsp_id); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_cmp(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.req_valid = 4'b0001;
    #1;
    wait_ready(n);
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b want 0001", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0100; #1;
    wait_rsp(n);
    checks++; if (n >= 20) begin errors++; $display("FAIL bp_rsp_timeout: waited %0d want <20", n); end
    drive_cmp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv, bus.req_ready} !== 11'b1_00_0100_0000) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b want 10001000000", i,
          {bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv, bus.req_ready}); end
      @(negedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %b want 1", bus.rsp_valid); end
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant_after: got %b want 0100", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0000; drive_cmp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    wait_rsp(n);
    checks++; if ({bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv} !== 6'b10_0000) begin
      errors++; $display("FAIL bp_zero_flags: got %b want 100000", {bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv}); end
  endtask

  task automatic test_late_done();
    @(negedge clk);
    bus.req_a[31:0] = 32'h7FC00000; bus.req_b[31:0] = 32'h3F800000;
    drive_cmp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL late_grant: got %b want 0001", bus.req_ready); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus.req_valid = 4'b0000;
      if (i == 6) bus.cmp_done = 1'b1;
      #1;
      checks++; if ({bus.cmp_act, bus.rsp_valid, bus.cmp_in1, bus.cmp_in2} !== {2'b10, 64'h7FC00000_3F800000}) begin
        errors++; $display("FAIL late_hold[%0d]: got act %b rsp %b in %h want act 1 rsp 0 in 7fc000003f800000",
          i, bus.cmp_act, bus.rsp_valid, {bus.cmp_in1, bus.cmp_in2}); end
    end
    @(negedge clk); #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv} !== 7'b1_00_0001) begin
      errors++; $display("FAIL late_rsp_t7: got %b want 1000001", {bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_great, bus.rsp_less, bus.rsp_inv}); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bus.req_a[63:32] = 32'hDEADBEEF; bus.req_b[63:32] = 32'h12345678;
    drive_cmp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant1: got %b want 0010", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0000; #1;
    checks++; if (bus.cmp_act !== 1'b1) begin errors++; $display("FAIL rm_in_issue: got %b want 1", bus.cmp_act); end
    @(negedge clk); rst = 1'b0; bus.req_valid = 4'b1111; #1;
    checks++; if ({bus.cmp_act, busy, bus.rsp_valid, bus.rsp_id, bus.req_ready} !== 9'b0) begin
      errors++; $display("FAIL rm_ctrl_reset: got %b want 000000000", {bus.cmp_act, busy, bus.rsp_valid, bus.rsp_id, bus.req_ready}); end
    checks++; if ({bus.cmp_in1, bus.cmp_in2} !== 64'h0) begin errors++; $display("FAIL rm_operands_reset: got %h want 0", {bus.cmp_in1, bus.cmp_in2}); end
    @(negedge clk); #1;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 5'b0) begin errors++; $display("FAIL rm_held: got %b want 00000", {bus.rsp_valid, bus.req_ready}); end
    @(negedge clk); rst = 1'b1; bus.req_valid = 4'b0011; #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_after_reset: got %b want 0001", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0000; #1;
    wait_rsp(n);
    checks++; if (n >= 20 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rm_rsp: got id %0d after %0d want id 0", bus.rsp_id, n); end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    drive_cmp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_single_op();
    test_contention();
    test_rotation();
    test_backpressure();
    test_late_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "time limit");
  end
endmodule
